// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - two-stage pipelined ALU with valid/ready handshake
//
// Purpose: S1 captures an operation (alu_ctl/a/b). S2 holds the computed
// result and flags until downstream takes them. Throughput is one op per
// cycle, latency is 2 cycles, and at most two ops are in flight.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   in_valid / in_ready    input handshake for alu_ctl, a, b
//   alu_ctl [3:0]          operation code
//   a, b [WIDTH-1:0]       operands
//   out_valid / out_ready  output handshake for result and flags
//   result [WIDTH-1:0]     operation result
//   zero                   result == 0
//   overflow               signed overflow on ADD/SUB
//   illegal                alu_ctl was not a supported code

module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Stage 1 registers
  logic             s1_valid;
  logic [3:0]       s1_ctl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2 valid; the result and flag registers are the output ports
  logic             s2_valid;

  logic             s2_load;
  logic             in_fire;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] c_result;
  logic             c_overflow;
  logic             c_illegal;

  // S2 takes S1 whenever S2 is empty or is being emptied this cycle.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  // in_ready is combinational from out_ready through s2_load.
  // It is forced low while reset is asserted.
  assign in_ready  = !reset && (!s1_valid || s2_load);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign sum  = s1_a + s1_b;
  assign diff = s1_a - s1_b;
  // Use a real signed compare rather than the sign of diff.
  // The sign of diff is wrong when a-b overflows.
  assign slt  = $signed(s1_a) < $signed(s1_b);

  always_comb begin
    c_result   = '0;
    c_overflow = 1'b0;
    c_illegal  = 1'b0;
    case (s1_ctl)
      OP_AND: c_result = s1_a & s1_b;
      OP_OR:  c_result = s1_a | s1_b;
      OP_NOR: c_result = ~(s1_a | s1_b);
      OP_ADD: begin
        c_result = sum;
        // Operands have the same sign and the sum's sign differs from them.
        c_overflow = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        c_result = diff;
        // Operand signs differ and the difference's sign differs from a.
        c_overflow = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                     (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SLT: c_result = {{(WIDTH-1){1'b0}}, slt};
      default: c_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_ctl   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_ctl   <= alu_ctl;
        s1_a     <= a;
        s1_b     <= b;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid <= 1'b1;
        result   <= c_result;
        zero     <= (c_result == '0);
        overflow <= c_overflow;
        illegal  <= c_illegal;
      end else if (out_ready) begin
        // If S2 drains and nothing replaces it, then S1 is empty.
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard testbench for alu_exec

module tb_alu_exec;

  typedef logic [34:0] exp_t; // {illegal, overflow, zero, result}

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  exp_t q[$];
  exp_t cur_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: compute with 64-bit signed arithmetic and range-check the result.
  function automatic exp_t model(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, t;
    logic [31:0] r;
    logic ov, ill;
    sx = $signed(x);
    sy = $signed(y);
    t = 0; r = '0; ov = 1'b0; ill = 1'b0;
    case (ctl)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin t = sx + sy; r = t[31:0]; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0110: begin t = sx - sy; r = t[31:0]; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    return {ill, ov, (r == 32'd0), r};
  endfunction

  task automatic offer(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    alu_ctl = ctl; a = x; b = y; cur_exp = e;
  endtask

  task automatic offer_m(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y);
    offer(ctl, x, y, model(ctl, x, y));
  endtask

  // Before each edge, record the handshakes: pop and compare on an output
  // transfer, and push on an input transfer. Sampling is 1 after the edge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("scoreboard", {29'd0, illegal, overflow, zero, result}, {29'd0, e});
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(cur_exp);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int acc0, out0, budget, n;
    logic pending;
    logic [3:0] ctls [7];
    logic [31:0] corner [5];
    logic [3:0] c;
    logic [31:0] x, y;

    ctls   = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
    corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctl = '0; a = '0; b = '0; cur_exp = '0;

    // Reset behavior
    @(posedge clk); @(posedge clk); #1;
    check("in_ready_in_reset", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {result, zero, overflow, illegal}, 0);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // ADD overflow and exact 2-cycle latency
    out_ready = 1'b1;
    offer(4'b0010, 32'h7FFFFFFF, 32'h1, {1'b0, 1'b1, 1'b0, 32'h80000000});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("latency_cycle1", out_valid, 0);
    tick();
    check("latency_cycle2", out_valid, 1);
    drain();

    // SUB resulting in zero; SLT with an operand pair whose a-b overflows
    in_valid = 1'b1;
    offer(4'b0110, 32'd5, 32'd5, {1'b0, 1'b0, 1'b1, 32'h0});
    tick();
    offer(4'b0111, 32'h80000000, 32'h1, {1'b0, 1'b0, 1'b0, 32'h1});
    tick();
    drain();

    // AND/OR/NOR at full throughput
    out0 = out_cnt;
    in_valid = 1'b1;
    offer(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, {3'b000, 32'hF000F000});
    check("full_rate_ready0", in_ready, 1);
    tick();
    offer(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, {3'b000, 32'hFFF0FFF0});
    check("full_rate_ready1", in_ready, 1);
    tick();
    offer(4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, {3'b000, 32'h000F000F});
    check("full_rate_ready2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("full_rate_outputs", out_cnt - out0, 3);
    drain();

    // Illegal opcode
    in_valid = 1'b1;
    offer(4'b0101, 32'd3, 32'd4, {1'b1, 1'b0, 1'b1, 32'h0});
    tick();
    drain();

    // Backpressure: four ADDs, out_ready low for 3 cycles
    acc0 = acc_cnt; out0 = out_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = acc_cnt - acc0;
      offer_m(4'b0010, 32'(n * 100), 32'(n + 1));
      tick();
    end
    check("stall_accepted", acc_cnt - acc0, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_hold", {29'd0, illegal, overflow, zero, result},
          {29'd0, model(4'b0010, 32'd0, 32'd1)});
    out_ready = 1'b1;
    budget = 20;
    while (acc_cnt - acc0 < 4 && budget > 0) begin
      n = acc_cnt - acc0;
      offer_m(4'b0010, 32'(n * 100), 32'(n + 1));
      tick();
      budget--;
    end
    check("stall_all_accepted", acc_cnt - acc0, 4);
    drain();
    check("stall_all_out", out_cnt - out0, 4);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    offer_m(4'b0010, 32'd11, 32'd22); tick();
    offer_m(4'b0110, 32'd50, 32'd8);  tick();
    in_valid = 1'b0;
    check("two_in_flight", q.size(), 2);
    reset = 1'b1;
    tick();
    check("flush_out_valid", out_valid, 0);
    reset = 1'b0;
    q.delete();
    #1;
    check("flush_in_ready", in_ready, 1);
    out0 = out_cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("flush_no_output", out_cnt - out0, 0);

    // Random traffic with random backpressure
    acc0 = acc_cnt;
    pending = 1'b0;
    budget = 2000;
    while (acc_cnt - acc0 < 40 && budget > 0) begin
      if (!pending) begin
        c = ctls[$urandom_range(0, 6)];
        x = ($urandom_range(0, 1) != 0) ? corner[$urandom_range(0, 4)] : $urandom;
        y = ($urandom_range(0, 1) != 0) ? corner[$urandom_range(0, 4)] : $urandom;
        offer_m(c, x, y);
        pending = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      n = acc_cnt;
      tick();
      if (acc_cnt != n) pending = 1'b0;
      budget--;
    end
    check("random_accepted", acc_cnt - acc0, 40);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
